// File: rtl/pn_adc_pkg.sv
// Shared types and default widths for the PN receiver ADC capture path.
package pn_adc_pkg;

    localparam int PN_ADC_DATA_W = 14;
    localparam int PN_ADC_ADDR_W = 14;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ARMED,
        CAPTURE,
        DONE
    } pn_adc_cap_state_t;

endpackage

// File: rtl/pn_adc_capture_ctrl_if.sv
// Sample-buffer write port driven by the capture sequencer.
interface pn_adc_capture_ctrl_if #(
    parameter int DATA_W = pn_adc_pkg::PN_ADC_DATA_W,
    parameter int ADDR_W = pn_adc_pkg::PN_ADC_ADDR_W
);
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;

    modport master (output WrEn, WrAddr, WrData);
    modport slave  (input  WrEn, WrAddr, WrData);
endinterface

// File: rtl/pn_adc_decim.sv
// Decimation down-counter: keep is high on one capture position in ratio+1.
// Only instantiated when PN_ADC_DECIM_EN is defined.
module pn_adc_decim #(
    parameter int DECIM_W = 8
) (
    input  logic               AClk,
    input  logic               ARstn,
    input  logic               load,
    input  logic               en,
    input  logic [DECIM_W-1:0] ratio,
    output logic               keep
);
    logic [DECIM_W-1:0] cnt;

    assign keep = (cnt == '0);

    // Loaded on the trigger sample (always kept); counts to 0 for the next keep.
    always_ff @(posedge AClk or negedge ARstn) begin
        if (!ARstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= ratio;
        end else if (en) begin
            cnt <= keep ? ratio : cnt - 1'b1;
        end
    end
endmodule

// File: rtl/pn_adc_capture_ctrl.sv
// Single-acquisition ADC capture sequencer: settle, arm, capture Len+1 samples.
// Optional decimation enabled with the PN_ADC_DECIM_EN macro.
module pn_adc_capture_ctrl
    import pn_adc_pkg::*;
#(
    parameter int DATA_W     = PN_ADC_DATA_W,
    parameter int ADDR_W     = PN_ADC_ADDR_W,
    parameter int SETTLE_CYC = 1024
`ifdef PN_ADC_DECIM_EN
    ,
    parameter int DECIM_W    = 8
`endif
) (
    input  logic                 AClk,
    input  logic                 ARstn,
    input  logic                 Start,
    input  logic                 Abort,
    input  logic                 Trig,
    input  logic [ADDR_W-1:0]    Len,
`ifdef PN_ADC_DECIM_EN
    input  logic [DECIM_W-1:0]   Decim,
`endif
    input  logic [DATA_W-1:0]    AdcData,
    output logic                 Busy,
    output logic                 Done,
    pn_adc_capture_ctrl_if.master wr
);
    localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

    pn_adc_cap_state_t   state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [ADDR_W-1:0]   len_q;
    logic                busy;
    logic                done;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                keep;

`ifdef PN_ADC_DECIM_EN
    logic [DECIM_W-1:0]  decim_q;

    always_ff @(posedge AClk or negedge ARstn) begin
        if (!ARstn) begin
            decim_q <= '0;
        end else if (!Abort && Start && (state == IDLE || state == DONE)) begin
            decim_q <= Decim;
        end
    end

    pn_adc_decim #(.DECIM_W(DECIM_W)) u_decim (
        .AClk  (AClk),
        .ARstn (ARstn),
        .load  (state == ARMED),
        .en    (state == CAPTURE),
        .ratio (decim_q),
        .keep  (keep)
    );
`else
    assign keep = 1'b1;
`endif

    // wr_addr always holds the last written address, so completion is
    // detected on the write at len_q and the counter can never wrap.
    always_ff @(posedge AClk or negedge ARstn) begin
        if (!ARstn) begin
            state      <= IDLE;
            settle_cnt <= '0;
            len_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else if (Abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            wr_en <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                        len_q      <= Len;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ARMED;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ARMED: begin
                    if (Trig) begin
                        state   <= CAPTURE;
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= AdcData;
                    end
                end
                CAPTURE: begin
                    if (wr_en && wr_addr == len_q) begin
                        state <= DONE;
                        wr_en <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        wr_en <= keep;
                        if (keep) begin
                            wr_addr <= wr_addr + 1'b1;
                            wr_data <= AdcData;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = busy;
    assign Done      = done;
    assign wr.WrEn   = wr_en;
    assign wr.WrAddr = wr_addr;
    assign wr.WrData = wr_data;
endmodule

// File: doc/pn_adc_capture_ctrl.md
# pn_adc_capture_ctrl

Sequencer for one acquisition of the buffered Red Pitaya ADC sample stream. It runs entirely in the ADC clock domain, on the global-buffered ADC clock. After a start request it lets the front end settle and waits for a trigger. It then writes a programmed number of consecutive (optionally decimated) samples into a sample buffer through a simple write port. It reports busy/done to the PN receiver control logic.

## Interface
Parameters:
- DATA_W, 14, ADC sample width
- ADDR_W, 14, buffer address width; max capture 2^ADDR_W samples
- SETTLE_CYC, 1024, AClk cycles discarded after Start before arming (≥1)
- DECIM_W, 8, decimation ratio width (used only with PN_ADC_DECIM_EN)

Ports:
- AClk  in  1  ADC clock (global buffered), single clock of the block
- ARstn  in  1  reset, asynchronous assert, active-low
- Start  in  1  one-cycle request; latches Len (and Decim)
- Abort  in  1  level/pulse; forces return to IDLE
- Trig  in  1  capture trigger, synchronous to AClk
- Len  in  ADDR_W  sample count minus one (captures Len+1 samples)
- Decim  in  DECIM_W  keep one sample in Decim+1 (PN_ADC_DECIM_EN only)
- AdcData  in  DATA_W  raw ADC sample
- Busy  out  1  high in SETTLE, ARMED, CAPTURE
- Done  out  1  high from end of capture until next Start or Abort
- WrEn  out  1  buffer write strobe
- WrAddr  out  ADDR_W  buffer write address
- WrData  out  DATA_W  buffer write data

## Operation
- States: IDLE, SETTLE, ARMED, CAPTURE, DONE.
- IDLE: Start → SETTLE. The settle counter loads SETTLE_CYC-1, and Len/Decim are latched. Trig is ignored.
- SETTLE: counter decrements each cycle; at 0 → ARMED. Trig is ignored, including in the transition cycle.
- ARMED: Trig=1 → CAPTURE. The sample on AdcData in that same cycle is sample 0.
- CAPTURE: each kept sample is written. The address starts at 0 and increments by 1 per write. After the write at address Len → DONE. Trig is ignored.
- DONE: Done=1, Busy=0. Start → SETTLE (Done clears the same cycle).
- Start in SETTLE/ARMED/CAPTURE is ignored.
- Abort, any state → IDLE next cycle:
  - WrEn=0 from that cycle onward; Done=0.
  - Abort has priority over Start and Trig in the same cycle.
- Len=0 captures exactly 1 sample. Len=2^ADDR_W-1 fills the buffer; the address never wraps.
- ARstn low, any time: state IDLE, counters 0. All outputs 0: Busy, Done, WrEn, WrAddr, WrData.

## Timing
- Registered outputs only; no combinational path from inputs to outputs.
- AdcData sampled in cycle N produces WrEn=1 with WrData=that sample in cycle N+1.
- Trig seen in cycle T gives the first write (WrAddr=0) in cycle T+1.
- Without decimation, writes are contiguous: the last write is in cycle T+1+Len.
- Done=1 and Busy=0 in cycle T+2+Len, the cycle after the last WrEn.
- Start in cycle S gives Busy=1 in cycle S+1. ARMED is entered in cycle S+1+SETTLE_CYC; Trig is honoured from that cycle.

## Configuration
- PN_ADC_DECIM_EN defined:
  - Decim port exists; the latched ratio D keeps samples at capture positions 0, D+1, 2(D+1)… (the trigger sample is always kept).
  - WrEn pulses once per D+1 cycles, and WrAddr increments only on writes.
  - Decim=0 behaves as undecimated.
- PN_ADC_DECIM_EN undefined: Decim port and decimation counter are absent; every sample in CAPTURE is written.

## Structure
- Shared package pn_adc_pkg holds:
  - state enum type pn_adc_cap_state_t (IDLE/SETTLE/ARMED/CAPTURE/DONE);
  - default width constants PN_ADC_DATA_W=14 and PN_ADC_ADDR_W=14.
- One sub-module, pn_adc_decim: a DECIM_W down-counter producing a keep strobe. It is loaded on capture start and instantiated only under PN_ADC_DECIM_EN.
- The FSM, settle counter and address counter stay in pn_adc_capture_ctrl.

## Test plan
- Reset mid-CAPTURE:
  - stimulus: ARstn low during CAPTURE at WrAddr=5;
  - required: all outputs 0 immediately; after release, state IDLE; a Trig alone produces no write.
- Basic capture:
  - stimulus: SETTLE_CYC=4, Len=7, Start at cycle 0, Trig at cycle 10, AdcData=cycle index;
  - required: Busy at cycle 1; WrEn cycles 11–18 with WrAddr 0–7 and WrData 10–17; Done at cycle 19.
- Early trigger:
  - stimulus: Trig held high from the Start cycle, SETTLE_CYC=4, Start at cycle 0;
  - required: no write before cycle 6; first write (WrAddr=0) carries the cycle-5 sample.
- Abort and ignored Start:
  - stimulus: Abort at WrAddr=3; separately, Start during CAPTURE;
  - required: WrEn=0 from the next cycle, Done=0, Busy=0; the mid-capture Start has no effect on count or addresses.
- Boundary lengths:
  - stimulus: Len=0, then Len=2^ADDR_W-1;
  - required: exactly 1 write at address 0; then 2^ADDR_W writes ending at all-ones, with no wrap.
- Decimation (PN_ADC_DECIM_EN):
  - stimulus: Decim=2, Len=3, Trig at cycle T;
  - required: writes at T+1, T+4, T+7, T+10 with samples T, T+3, T+6, T+9; Done at T+11.
